// File: rtl/axi_pkg.sv
// Shared constants for the AXI4-Lite slave read path.
// Response codes and read-FSM state encoding.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RESP  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axi_byte_mem.sv
// Byte-wide register memory with one backdoor write port
// and a combinational 4-byte little-endian wrapping read.
module axi_byte_mem #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // AW-bit index arithmetic gives the wrap at the top for free
  always_comb begin
    logic [AW-1:0] idx;
    rdata = '0;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = raddr + AW'(i);
      rdata[8*i +: 8] = mem[idx];
    end
  end

endmodule

// File: rtl/axi_slave_read.sv
// AXI4-Lite AR/R responder over a byte memory.
// One outstanding read; IDLE -> FETCH -> RESP.
module axi_slave_read
  import axi_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic              bd_we,
  input  logic [AW-1:0]     bd_addr,
  input  logic [7:0]        bd_data
);

  rd_state_e         state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       mem_rdata;
  logic              oob;

  assign oob = addr_q >= ADDR_W'(DEPTH);

  axi_byte_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (ACLK),
    .rst  (ARESET),
    .we   (bd_we),
    .waddr(bd_addr),
    .wdata(bd_data),
    .raddr(addr_q[AW-1:0]),
    .rdata(mem_rdata)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ARREADY && ARVALID) begin
            addr_q  <= ARADDR;
            ARREADY <= 1'b0;
            state   <= ST_FETCH;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        ST_FETCH: begin
          RDATA  <= oob ? 32'h0 : mem_rdata;
          RRESP  <= oob ? RESP_SLVERR : RESP_OKAY;
          RVALID <= 1'b1;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
            ARREADY <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          ARREADY <= 1'b0;
          RVALID  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_read.sv
// Directed bench for axi_slave_read: timing, back-pressure,
// wrap, error response, backdoor race and mid-transaction reset.
module tb_axi_slave_read;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam int AW     = $clog2(DEPTH);

  logic              ACLK;
  logic              ARESET;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;
  logic              bd_we;
  logic [AW-1:0]     bd_addr;
  logic [7:0]        bd_data;

  int pass_cnt;
  int total_cnt;

  axi_slave_read #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .ARADDR (ARADDR),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA  (RDATA),
    .RRESP  (RRESP),
    .RVALID (RVALID),
    .RREADY (RREADY),
    .bd_we  (bd_we),
    .bd_addr(bd_addr),
    .bd_data(bd_data)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    tick();
    bd_we   = 1'b0;
  endtask

  // Full read with RREADY raised once RVALID is seen.
  task automatic do_read(input logic [ADDR_W-1:0] a,
                         output logic [31:0] d,
                         output logic [1:0] r,
                         output bit timeout);
    int n;
    timeout = 1'b0;
    d = '0;
    r = '0;
    ARADDR  = a;
    ARVALID = 1'b1;
    RREADY  = 1'b0;
    n = 0;
    while (!ARREADY && n < 20) begin
      tick();
      n++;
    end
    if (!ARREADY) timeout = 1'b1;
    tick();
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 20) begin
      tick();
      n++;
    end
    if (!RVALID) timeout = 1'b1;
    d = RDATA;
    r = RRESP;
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
  endtask

  task automatic apply_reset();
    ARESET = 1'b1;
    tick();
    tick();
    ARESET = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    #1;
    total_cnt++;
    if (ARREADY !== 1'b0 || RVALID !== 1'b0 || RDATA !== 32'h0 ||
        RRESP !== 2'b00) begin
      $display("FAIL reset_outputs: got ARREADY=%b RVALID=%b RDATA=%h RRESP=%b want 0 0 0 00",
               ARREADY, RVALID, RDATA, RRESP);
    end else pass_cnt++;
    tick();
    ARESET = 1'b0;
    tick();
    total_cnt++;
    if (ARREADY !== 1'b1) begin
      $display("FAIL reset_arready_rise: got %b want 1", ARREADY);
    end else pass_cnt++;
  endtask

  task automatic test_aligned();
    bd_write(0, 8'h78);
    bd_write(1, 8'h56);
    bd_write(2, 8'h34);
    bd_write(3, 8'h12);
    ARADDR  = 0;
    ARVALID = 1'b1;
    RREADY  = 1'b1;
    tick();
    ARVALID = 1'b0;
    total_cnt++;
    if (ARREADY !== 1'b0 || RVALID !== 1'b0) begin
      $display("FAIL aligned_fetch: got ARREADY=%b RVALID=%b want 0 0", ARREADY, RVALID);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (RVALID !== 1'b1 || RDATA !== 32'h12345678 || RRESP !== 2'b00) begin
      $display("FAIL aligned_data: got RVALID=%b RDATA=%h RRESP=%b want 1 12345678 00",
               RVALID, RDATA, RRESP);
    end else pass_cnt++;
    tick();
    RREADY = 1'b0;
    total_cnt++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1 || RDATA !== 32'h0) begin
      $display("FAIL aligned_done: got RVALID=%b ARREADY=%b RDATA=%h want 0 1 0",
               RVALID, ARREADY, RDATA);
    end else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit stable;
    bd_write(1, 8'h78);
    bd_write(2, 8'h56);
    bd_write(3, 8'h34);
    bd_write(4, 8'h12);
    ARADDR  = 1;
    ARVALID = 1'b1;
    RREADY  = 1'b0;
    tick();
    ARVALID = 1'b0;
    tick();
    total_cnt++;
    if (RVALID !== 1'b1 || RDATA !== 32'h12345678) begin
      $display("FAIL unaligned_data: got RVALID=%b RDATA=%h want 1 12345678", RVALID, RDATA);
    end else pass_cnt++;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (RVALID !== 1'b1 || RDATA !== 32'h12345678 || ARREADY !== 1'b0) stable = 1'b0;
    end
    total_cnt++;
    if (!stable) begin
      $display("FAIL backpressure_hold: got RVALID=%b RDATA=%h ARREADY=%b want 1 12345678 0",
               RVALID, RDATA, ARREADY);
    end else pass_cnt++;
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    total_cnt++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      $display("FAIL backpressure_release: got RVALID=%b ARREADY=%b want 0 1", RVALID, ARREADY);
    end else pass_cnt++;
  endtask

  task automatic test_wrap_error();
    logic [31:0] d;
    logic [1:0]  r;
    bit          to;
    bd_write(62, 8'hAA);
    bd_write(63, 8'hBB);
    bd_write(0, 8'hCC);
    bd_write(1, 8'hDD);
    do_read(62, d, r, to);
    total_cnt++;
    if (to || d !== 32'hDDCCBBAA || r !== 2'b00) begin
      $display("FAIL wrap_read: got RDATA=%h RRESP=%b timeout=%0d want DDCCBBAA 00 0", d, r, to);
    end else pass_cnt++;
    do_read(64, d, r, to);
    total_cnt++;
    if (to || d !== 32'h0 || r !== 2'b10) begin
      $display("FAIL oob_read: got RDATA=%h RRESP=%b timeout=%0d want 0 10 0", d, r, to);
    end else pass_cnt++;
  endtask

  task automatic test_read_after_reset();
    logic [31:0] d;
    logic [1:0]  r;
    bit          to;
    bd_write(7, 8'h5A);
    apply_reset();
    do_read(7, d, r, to);
    total_cnt++;
    if (to || d !== 32'h0 || r !== 2'b00) begin
      $display("FAIL read_after_reset: got RDATA=%h RRESP=%b timeout=%0d want 0 00 0", d, r, to);
    end else pass_cnt++;
  endtask

  task automatic test_backdoor_race();
    logic [31:0] d;
    logic [1:0]  r;
    bit          to;
    bd_write(0, 8'h78);
    bd_write(1, 8'h56);
    bd_write(2, 8'h34);
    bd_write(3, 8'h12);
    ARADDR  = 0;
    ARVALID = 1'b1;
    RREADY  = 1'b1;
    tick();
    ARVALID = 1'b0;
    bd_we   = 1'b1;
    bd_addr = 0;
    bd_data = 8'hFF;
    tick();
    bd_we = 1'b0;
    total_cnt++;
    if (RVALID !== 1'b1 || RDATA !== 32'h12345678) begin
      $display("FAIL race_old_value: got RVALID=%b RDATA=%h want 1 12345678", RVALID, RDATA);
    end else pass_cnt++;
    tick();
    RREADY = 1'b0;
    do_read(0, d, r, to);
    total_cnt++;
    if (to || d !== 32'h123456FF) begin
      $display("FAIL race_new_value: got RDATA=%h timeout=%0d want 123456FF 0", d, to);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    bit          to;
    ARADDR  = 0;
    ARVALID = 1'b1;
    RREADY  = 1'b0;
    tick();
    ARVALID = 1'b0;
    tick();
    total_cnt++;
    if (RVALID !== 1'b1) begin
      $display("FAIL mid_in_resp: got RVALID=%b want 1", RVALID);
    end else pass_cnt++;
    ARESET = 1'b1;
    #1;
    total_cnt++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b0) begin
      $display("FAIL mid_async_abort: got RVALID=%b ARREADY=%b want 0 0", RVALID, ARREADY);
    end else pass_cnt++;
    tick();
    ARESET = 1'b0;
    tick();
    total_cnt++;
    if (ARREADY !== 1'b1) begin
      $display("FAIL mid_arready_rise: got %b want 1", ARREADY);
    end else pass_cnt++;
    do_read(0, d, r, to);
    total_cnt++;
    if (to || d !== 32'h0 || r !== 2'b00) begin
      $display("FAIL mid_read_cleared: got RDATA=%h RRESP=%b timeout=%0d want 0 00 0", d, r, to);
    end else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    ARESET  = 1'b1;
    ARADDR  = '0;
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    bd_we   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    tick();
    test_reset();
    test_aligned();
    test_backpressure();
    test_wrap_error();
    test_read_after_reset();
    test_backdoor_race();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axi_slave_read.md
Name: axi_slave_read

Overview:
- AXI4-Lite read-channel responder (AR/R) backed by a byte-addressed memory.
- It is the read-side counterpart of axi_slave, which handles AW/W/B. It answers axi_master's ARVALID/ARADDR requests with RDATA/RVALID.
- A backdoor byte-write port preloads and modifies the memory.
- Returns 4 bytes little-endian starting at any byte address; unaligned addresses are allowed.

Parameters:
- DEPTH, 64, memory size in bytes; must be a power of two, >= 4.
- ADDR_W, 32, width of ARADDR.

Ports:
- ACLK  in  1  clock; all logic updates on the rising edge.
- ARESET  in  1  asynchronous reset, active-high.
- ARADDR  in  ADDR_W  read byte address.
- ARVALID  in  1  address valid from master.
- ARREADY  out  1  slave accepts the address.
- RDATA  out  32  read data, little-endian.
- RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
- RVALID  out  1  read data valid.
- RREADY  in  1  master accepts the data.
- bd_we  in  1  backdoor byte write enable.
- bd_addr  in  log2(DEPTH)  backdoor byte address.
- bd_data  in  8  backdoor byte value.

Behaviour:
- Reset (async, while ARESET=1):
  - state=IDLE, ARREADY=0, RVALID=0, RDATA=0, RRESP=0.
  - All memory bytes = 8'h00.
  - ARREADY rises on the first edge after ARESET falls.
- FSM states: IDLE, FETCH, RESP.
- IDLE:
  - ARREADY=1, RVALID=0.
  - ARVALID&ARREADY at edge N: latch ARADDR, ARREADY->0, go to FETCH.
- FETCH (one cycle):
  - Byte i of RDATA (bits 8i+7:8i) = mem[(addr+i) mod DEPTH], i=0..3.
  - Bytes wrap around the top of memory.
  - If addr >= DEPTH: RDATA=0, RRESP=SLVERR; otherwise RRESP=OKAY.
  - At edge N+1: RVALID=1, go to RESP.
- RESP:
  - RVALID, RDATA and RRESP are held stable until RREADY=1.
  - RVALID&RREADY at an edge: RVALID->0, RDATA->0, RRESP->0, ARREADY->1, go to IDLE.
- Latency:
  - AR handshake at edge N -> RVALID high after edge N+1.
  - If RREADY is already high, R handshake at edge N+2.
  - Minimum 3 cycles per transaction; the next AR is accepted at edge N+3 at the earliest.
- ARVALID while not in IDLE is ignored; ARREADY=0 there, and the master must hold its request.
- Backdoor write:
  - bd_we=1 writes mem[bd_addr]=bd_data at the edge, in any state.
  - A backdoor write to a byte fetched in the same FETCH cycle returns the old value.
  - The new value is visible to subsequent reads.
- ARESET mid-transaction aborts the transaction immediately: RVALID=0 and the FSM returns to IDLE asynchronously.
- ARVALID dropping during RESP has no effect on the pending response.

Decomposition:
- axi_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - FSM state encoding: IDLE=2'd0, FETCH=2'd1, RESP=2'd2.
- Sub-module axi_byte_mem:
  - DEPTH-byte register array with one write port (bd_*) and a combinational 4-byte wrapping read at a given address.
  - Async clear on ARESET.
- axi_slave_read holds only the FSM and the channel registers.

Test Plan:
1. Aligned read: preload bytes 0..3 = 78,56,34,12; ARADDR=0, ARVALID=1, RREADY=1 -> ARREADY handshake at edge N, RVALID high after N+1, RDATA=32'h12345678, RRESP=00, ARREADY high again after N+2.
2. Unaligned read with back-pressure: preload 1..4 = 78,56,34,12; ARADDR=1, hold RREADY=0 for 5 cycles -> RVALID stays 1, RDATA stays 32'h12345678 throughout, completes on the first cycle with RREADY=1.
3. Wrap and error: preload 62,63,0,1 = AA,BB,CC,DD, ARADDR=62 -> RDATA=32'hDDCCBBAA, RRESP=00; then ARADDR=64 -> RDATA=0, RRESP=10.
4. Read after reset: read ARADDR=7 without any preload -> RDATA=0, RRESP=00.
5. Backdoor race: during FETCH of ARADDR=0 (bytes 78,56,34,12), write bd_addr=0, bd_data=8'hFF -> RDATA=32'h12345678; the next read of address 0 -> 32'h123456FF.
6. Reset mid-transaction: assert ARESET while in RESP -> RVALID=0 and ARREADY=0 immediately; after release, ARREADY=1 on the first edge and a new read of address 0 returns 0.
